// File: rtl/bram_port_arbiter.sv
// Two-master arbiter for the data-side BRAM port. M0 (CPU) has fixed priority.
// A starvation guard protects M1 (DMA), which may also lock the port for a bounded burst.
module bram_port_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [3:0]  m0_we,
    input  logic [14:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [3:0]  m1_we,
    input  logic [14:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [14:0] bram_addr,
    output logic [31:0] bram_din,
    input  logic [31:0] bram_dout,
    output logic        starved
);

    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam int BW   = $clog2(BURST_MAX + 1);
    localparam int LAST = READ_LATENCY - 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

    typedef enum logic [1:0] {IDLE, M1_BURST, RELEASE} state_t;

    state_t                   state;
    logic [SW-1:0]            starve_cnt;
    logic [BW-1:0]            burst_cnt;
    logic [READ_LATENCY-1:0]  pipe_valid;
    logic [READ_LATENCY-1:0]  pipe_id;
    logic                     grant0;
    logic                     grant1;
    logic                     starve_win;
    logic                     idle_arb;
    logic                     rd_issue;

    // A burst that loses its lock or request falls back to ordinary arbitration in the same cycle.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        starve_win = 1'b0;
        idle_arb   = (state == IDLE) || (state == M1_BURST && !(m1_req && m1_lock));
        if (!reset) begin
            grant0 = 1'b0;
        end else if (state == RELEASE) begin
            grant0 = m0_req;
        end else if (idle_arb) begin
            if (m0_req && m1_req) begin
                if (starve_cnt == STARVE_TOP) begin
                    grant1     = 1'b1;
                    starve_win = 1'b1;
                end else begin
                    grant0 = 1'b1;
                end
            end else begin
                grant0 = m0_req;
                grant1 = m1_req;
            end
        end else if (!(burst_cnt == BURST_TOP && m0_req)) begin
            grant1 = 1'b1;
        end
    end

    always_comb begin
        bram_we   = 4'b0000;
        bram_addr = 15'h0000;
        bram_din  = 32'h0000_0000;
        if (grant0) begin
            bram_we   = m0_we;
            bram_addr = m0_addr;
            bram_din  = m0_wdata;
        end else if (grant1) begin
            bram_we   = m1_we;
            bram_addr = m1_addr;
            bram_din  = m1_wdata;
        end
    end

    assign m0_gnt   = grant0;
    assign m1_gnt   = grant1;
    assign starved  = starve_win;
    assign bram_en  = grant0 | grant1;
    assign rd_issue = bram_en && (bram_we == 4'b0000);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            pipe_valid <= '0;
            pipe_id    <= '0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= 32'h0000_0000;
            m1_rdata   <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant1 && m1_lock) begin
                        state     <= M1_BURST;
                        burst_cnt <= BW'(1);
                    end
                end
                M1_BURST: begin
                    if (!(m1_req && m1_lock)) begin
                        state <= IDLE;
                    end else if (!grant1) begin
                        state <= RELEASE;
                    end else if (burst_cnt != BURST_TOP) begin
                        // Saturate so a forced release is still taken once M0 shows up.
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!m1_req || grant1) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_TOP) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            pipe_valid[0] <= rd_issue;
            pipe_id[0]    <= grant1;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end

            m0_rvalid <= pipe_valid[LAST] && !pipe_id[LAST];
            m1_rvalid <= pipe_valid[LAST] && pipe_id[LAST];
            if (pipe_valid[LAST] && !pipe_id[LAST]) begin
                m0_rdata <= bram_dout;
            end
            if (pipe_valid[LAST] && pipe_id[LAST]) begin
                m1_rdata <= bram_dout;
            end
        end
    end

endmodule
